fetch_unit: RTL and testbench

- Instruction fetch stage. Owns the program counter and issues word-aligned read requests to instruction memory.
- Returns each fetched instruction, tagged with its PC, to decode through a one-entry valid/ready output buffer.
- It is the consumer side of next-PC generation: sequential PC+4 advance is internal, and branch/jump targets arrive on a redirect port.
- At most one memory request is outstanding at a time.

---
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word-aligned imem read at a
// time and hands each instruction with its PC to decode via a one-entry buffer.
`timescale 1ns/1ps
module fetch_unit #(
   parameter int unsigned           ADDR_W   = 32,
   parameter int unsigned           INST_W   = 32,
   parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [INST_W-1:0] imem_rsp_data,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst_data,
   output logic [ADDR_W-1:0] inst_pc,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc
);

   typedef enum logic [1:0] {
      S_REQ       = 2'd0,
      S_WAIT      = 2'd1,
      S_WAIT_DROP = 2'd2
   } state_e;

   state_e              state_q;
   logic [ADDR_W-1:0]   pc_q;
   logic                buf_valid_q;
   logic [INST_W-1:0]   buf_data_q;
   logic [ADDR_W-1:0]   buf_pc_q;

   logic                req_fire;
   logic [ADDR_W-1:0]   redirect_aligned;
   logic                unused_redirect_lsb;

   assign imem_req_valid   = (state_q == S_REQ) && !buf_valid_q && !rst;
   assign imem_req_addr    = pc_q;
   assign req_fire         = imem_req_valid && imem_req_ready;
   assign redirect_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};
   assign unused_redirect_lsb = ^redirect_pc[1:0];

   assign inst_valid = buf_valid_q;
   assign inst_data  = buf_data_q;
   assign inst_pc    = buf_pc_q;

   // Redirect overrides the normal flow; an in-flight response becomes a drop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_REQ;
         pc_q        <= RESET_PC;
         buf_valid_q <= 1'b0;
         buf_data_q  <= '0;
         buf_pc_q    <= '0;
      end else if (redirect_valid) begin
         pc_q        <= redirect_aligned;
         buf_valid_q <= 1'b0;
         case (state_q)
            S_REQ:       state_q <= req_fire ? S_WAIT_DROP : S_REQ;
            S_WAIT:      state_q <= imem_rsp_valid ? S_REQ : S_WAIT_DROP;
            S_WAIT_DROP: state_q <= imem_rsp_valid ? S_REQ : S_WAIT_DROP;
            default:     state_q <= S_REQ;
         endcase
      end else begin
         if (buf_valid_q && inst_ready) begin
            buf_valid_q <= 1'b0;
         end
         case (state_q)
            S_REQ: begin
               if (req_fire) begin
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  buf_valid_q <= 1'b1;
                  buf_data_q  <= imem_rsp_data;
                  buf_pc_q    <= pc_q;
                  pc_q        <= pc_q + ADDR_W'(4);
                  state_q     <= S_REQ;
               end
            end
            S_WAIT_DROP: begin
               if (imem_rsp_valid) begin
                  state_q <= S_REQ;
               end
            end
            default: state_q <= S_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable instruction memory.
`timescale 1ns/1ps
module tb_fetch_unit;

   localparam int unsigned   ADDR_W   = 32;
   localparam int unsigned   INST_W   = 32;
   localparam logic [31:0]   RST_PC   = 32'h0040_0000;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int checks   = 0;
   int failures = 0;
   int lat      = 1;
   int cnt      = 0;
   int req_cnt  = 0;
   logic [31:0] raddr;

   fetch_unit #(.ADDR_W(ADDR_W), .INST_W(INST_W), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_data(inst_data), .inst_pc(inst_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // Memory: accept sampled just before the edge, response after lat edges.
   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         if (cnt == 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(raddr);
         end else begin
            imem_rsp_valid = 1'b0;
         end
         if (cnt > 0) cnt--;
         #4;
         if (rst) begin
            cnt = 0;
         end else if (imem_req_valid && imem_req_ready) begin
            cnt   = lat;
            raddr = imem_req_addr;
            req_cnt++;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; imem_req_ready = 1'b0; inst_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0;
      cyc(); cyc();
      checks++;
      if (imem_req_valid !== 1'b0) begin
         failures++; $display("FAIL reset_req_valid got %b exp 0", imem_req_valid);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0) begin
         failures++;
         $display("FAIL reset_buffer got v=%b d=%h pc=%h exp 0/0/0", inst_valid, inst_data, inst_pc);
      end
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
         failures++;
         $display("FAIL reset_req got v=%b a=%h exp 1/%h", imem_req_valid, imem_req_addr, RST_PC);
      end
   endtask

   task automatic test_free_run();
      int start;
      logic exp_v;
      logic [31:0] exp_pc;
      start = req_cnt;
      lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         cyc();
         exp_v = (i % 3 == 2);
         checks++;
         if (inst_valid !== exp_v) begin
            failures++; $display("FAIL free_run_valid cyc%0d got %b exp %b", i, inst_valid, exp_v);
         end
         if (exp_v) begin
            exp_pc = RST_PC + 32'((i - 2) / 3 * 4);
            checks++;
            if (inst_pc !== exp_pc || inst_data !== mem_word(exp_pc)) begin
               failures++;
               $display("FAIL free_run_inst got pc=%h d=%h exp pc=%h d=%h", inst_pc, inst_data, exp_pc, mem_word(exp_pc));
            end
         end
      end
      checks++;
      if (req_cnt - start !== 3) begin
         failures++; $display("FAIL free_run_reqs got %0d exp 3", req_cnt - start);
      end
   endtask

   task automatic test_backpressure();
      inst_ready = 1'b0;
      cyc(); cyc();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (inst_valid !== 1'b1 || inst_pc !== 32'h0040_000C ||
             inst_data !== mem_word(32'h0040_000C) || imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_hold got v=%b pc=%h d=%h rv=%b exp 1/0040000c/%h/0",
                     inst_valid, inst_pc, inst_data, imem_req_valid, mem_word(32'h0040_000C));
         end
         cyc();
      end
      inst_ready = 1'b1;
      cyc();
      checks++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0040_0010) begin
         failures++;
         $display("FAIL backpressure_release got v=%b rv=%b a=%h exp 0/1/00400010", inst_valid, imem_req_valid, imem_req_addr);
      end
   endtask

   task automatic test_mem_stall();
      int start;
      int seen;
      imem_req_ready = 1'b0; lat = 4;
      start = req_cnt;
      seen  = 0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         checks++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0040_0010) begin
            failures++; $display("FAIL stall_addr got v=%b a=%h exp 1/00400010", imem_req_valid, imem_req_addr);
         end
      end
      imem_req_ready = 1'b1;
      cyc();
      imem_req_ready = 1'b0;
      for (int j = 1; j <= 6; j++) begin
         cyc();
         if (inst_valid === 1'b1) begin
            seen++;
            checks++;
            if (j != 4 || inst_pc !== 32'h0040_0010 || inst_data !== mem_word(32'h0040_0010)) begin
               failures++;
               $display("FAIL stall_inst got cyc=%0d pc=%h d=%h exp cyc=4 pc=00400010", j, inst_pc, inst_data);
            end
         end
      end
      checks++;
      if (seen != 1 || req_cnt - start != 1) begin
         failures++; $display("FAIL stall_count got inst=%0d req=%0d exp 1/1", seen, req_cnt - start);
      end
   endtask

   task automatic test_redirect_wait();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0010;
      cyc();
      redirect_valid = 1'b0;
      checks++;
      if (imem_req_addr !== 32'h0000_0010) begin
         failures++; $display("FAIL redir_req_addr got %h exp 00000010", imem_req_addr);
      end
      lat = 3; imem_req_ready = 1'b1;
      cyc();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
      cyc();
      redirect_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            failures++; $display("FAIL redir_wait_drop got rv=%b v=%b exp 0/0", imem_req_valid, inst_valid);
         end
         cyc();
      end
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0100 || inst_valid !== 1'b0) begin
         failures++;
         $display("FAIL redir_wait_next got rv=%b a=%h v=%b exp 1/00000100/0", imem_req_valid, imem_req_addr, inst_valid);
      end
   endtask

   task automatic test_redirect_coincident();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0020;
      cyc();
      redirect_valid = 1'b0;
      lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b0;
      cyc();
      imem_req_ready = 1'b0;
      cyc();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h0000_0020) begin
         failures++; $display("FAIL coin_buffered got v=%b pc=%h exp 1/00000020", inst_valid, inst_pc);
      end
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0080; inst_ready = 1'b1;
      cyc();
      redirect_valid = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0080) begin
         failures++;
         $display("FAIL coin_flush got v=%b rv=%b a=%h exp 0/1/00000080", inst_valid, imem_req_valid, imem_req_addr);
      end
      imem_req_ready = 1'b1;
      cyc();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
      cyc();
      redirect_valid = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0040) begin
         failures++;
         $display("FAIL coin_rsp got v=%b rv=%b a=%h exp 0/1/00000040", inst_valid, imem_req_valid, imem_req_addr);
      end
      // Redirect on the same edge as the request handshake.
      lat = 2; imem_req_ready = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0060;
      cyc();
      redirect_valid = 1'b0; imem_req_ready = 1'b0;
      cyc();
      checks++;
      if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0000_0060) begin
         failures++; $display("FAIL coin_fire_drop got rv=%b a=%h exp 0/00000060", imem_req_valid, imem_req_addr);
      end
      cyc();
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0060 || inst_valid !== 1'b0) begin
         failures++;
         $display("FAIL coin_fire_next got rv=%b a=%h v=%b exp 1/00000060/0", imem_req_valid, imem_req_addr, inst_valid);
      end
   endtask

   task automatic test_wrap();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      cyc();
      redirect_valid = 1'b0;
      checks++;
      if (imem_req_addr !== 32'hFFFF_FFFC) begin
         failures++; $display("FAIL wrap_align got %h exp fffffffc", imem_req_addr);
      end
      lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
      cyc();
      imem_req_ready = 1'b0;
      cyc();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst_data !== mem_word(32'hFFFF_FFFC)) begin
         failures++; $display("FAIL wrap_inst got v=%b pc=%h d=%h exp 1/fffffffc", inst_valid, inst_pc, inst_data);
      end
      cyc();
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0000) begin
         failures++; $display("FAIL wrap_next got rv=%b a=%h exp 1/00000000", imem_req_valid, imem_req_addr);
      end
   endtask

   task automatic test_reset_mid_wait();
      lat = 5; imem_req_ready = 1'b1;
      cyc();
      imem_req_ready = 1'b0;
      cyc();
      rst = 1'b1;
      cyc();
      checks++;
      if (imem_req_valid !== 1'b0) begin
         failures++; $display("FAIL midrst_req_valid got %b exp 0", imem_req_valid);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
         failures++;
         $display("FAIL midrst_state got v=%b rv=%b a=%h exp 0/1/%h", inst_valid, imem_req_valid, imem_req_addr, RST_PC);
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_backpressure();
      test_mem_stall();
      test_redirect_wait();
      test_redirect_coincident();
      test_wrap();
      test_reset_mid_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
